dmem_bus_ctrl: RTL and testbench

DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

---
 rtl/dmem_bus_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns mem-stage load/store requests into single
// outstanding transactions on a request/addr_ok/data_ok bus, stalling the pipe meanwhile.
module dmem_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [2:0]  r_size_i,
  input  logic [2:0]  w_size_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_post_rst;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_access;
  logic        w_new;
  logic        w_capture;
  logic        w_unused;

  assign w_access = (mem_ce_i | (|mem_we_i)) & ~flush_i;
  // The cycle right after reset never starts an access, so stall_o stays low then.
  assign w_new    = (r_state == S_IDLE) & w_access & ~r_post_rst;
  assign w_unused = r_size_i[2] ^ w_size_i[2];

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    stall_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_new) begin
          w_next  = S_REQ;
          stall_o = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (flush_i) begin
          if (data_addr_ok && !data_data_ok) w_next = S_CANCEL;
          else                               w_next = S_IDLE;
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            w_next    = S_DONE;
            w_capture = ~r_wr;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (data_data_ok) begin
          w_next    = flush_i ? S_IDLE : S_DONE;
          w_capture = ~flush_i & ~r_wr;
        end else if (flush_i) begin
          w_next = S_CANCEL;
        end
      end
      S_DONE: begin
        if (flush_i || !pipe_stall_i) w_next = S_IDLE;
      end
      S_CANCEL: begin
        stall_o = w_access;
        if (data_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_post_rst <= 1'b1;
      r_wr       <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 32'd0;
      r_wstrb    <= 4'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_post_rst <= 1'b0;
      if (w_new) begin
        r_wr    <= |mem_we_i;
        r_size  <= (|mem_we_i) ? w_size_i[1:0] : r_size_i[1:0];
        r_addr  <= mem_addr_i;
        r_wstrb <= mem_we_i;
        r_wdata <= mem_wdata_i;
      end
      if (w_capture) r_rdata <= data_rdata;
    end
  end

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wstrb = r_wstrb;
  assign data_wdata = r_wdata;
  assign rdata_o    = r_rdata;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Testbench for dmem_bus_ctrl: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model (pending / outstanding / discard / done).
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i;
  logic [3:0]  mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  r_size_i;
  logic [2:0]  w_size_i;
  logic        flush_i;
  logic        pipe_stall_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic        mPending, mOutstanding, mDiscard, mDone, mPostRst;
  logic        mWr;
  logic [1:0]  mSize;
  logic [31:0] mAddr, mWdata, mRdata;
  logic [3:0]  mStrb;

  dmem_bus_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ce_i     (mem_ce_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .r_size_i     (r_size_i),
    .w_size_i     (w_size_i),
    .flush_i      (flush_i),
    .pipe_stall_i (pipe_stall_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic acc;
    logic expStall;
    acc      = (mem_ce_i | (|mem_we_i)) & ~flush_i;
    expStall = !mPostRst && !mDone && (mPending || (mOutstanding && !mDiscard) || acc);
    if (rst) checkVal("stall_o", {31'd0, stall_o}, {31'd0, expStall});
    checkVal("data_req",   {31'd0, data_req},   {31'd0, mPending});
    checkVal("data_wr",    {31'd0, data_wr},    {31'd0, mWr});
    checkVal("data_size",  {30'd0, data_size},  {30'd0, mSize});
    checkVal("data_addr",  data_addr,           mAddr);
    checkVal("data_wstrb", {28'd0, data_wstrb}, {28'd0, mStrb});
    checkVal("data_wdata", data_wdata,          mWdata);
    checkVal("rdata_o",    rdata_o,             mRdata);
  endtask

  task automatic modelUpdate();
    logic acc, wasPost, d;
    acc     = (mem_ce_i | (|mem_we_i)) & ~flush_i;
    wasPost = mPostRst;
    if (!rst) begin
      {mPending, mOutstanding, mDiscard, mDone, mWr} = '0;
      mPostRst = 1'b1;
      mSize = 2'd0; mAddr = 32'd0; mWdata = 32'd0; mRdata = 32'd0; mStrb = 4'd0;
    end else begin
      mPostRst = 1'b0;
      if (mPending) begin
        mPending = 1'b0;
        if (flush_i) begin
          if (data_addr_ok && !data_data_ok) begin
            mOutstanding = 1'b1;
            mDiscard     = 1'b1;
          end
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            mDone = 1'b1;
            if (!mWr) mRdata = data_rdata;
          end else begin
            mOutstanding = 1'b1;
          end
        end else begin
          mPending = 1'b1;
        end
      end else if (mOutstanding) begin
        d = mDiscard | flush_i;
        if (data_data_ok) begin
          mOutstanding = 1'b0;
          mDiscard     = 1'b0;
          if (!d) begin
            mDone = 1'b1;
            if (!mWr) mRdata = data_rdata;
          end
        end else begin
          mDiscard = d;
        end
      end else if (mDone) begin
        if (flush_i || !pipe_stall_i) mDone = 1'b0;
      end else if (!wasPost && acc) begin
        mPending = 1'b1;
        mWr      = |mem_we_i;
        mSize    = (|mem_we_i) ? w_size_i[1:0] : r_size_i[1:0];
        mAddr    = mem_addr_i;
        mWdata   = mem_wdata_i;
        mStrb    = mem_we_i;
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idleInputs();
    mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    r_size_i = 0; w_size_i = 0; flush_i = 0; pipe_stall_i = 0;
    data_addr_ok = 0; data_rdata = 0; data_data_ok = 0;
  endtask

  initial begin
    logic [3:0] strbs [7];
    strbs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    {mPending, mOutstanding, mDiscard, mDone, mPostRst, mWr} = '0;
    mSize = 0; mAddr = 0; mWdata = 0; mRdata = 0; mStrb = 0;

    idleInputs();
    rst = 0;
    applyStimulus();
    applyStimulus();
    rst = 1;
    applyStimulus();
    checkVal("reset_rdata", rdata_o, 32'd0);

    // Load word, addr_ok after one wait cycle, data_ok two cycles later
    mem_ce_i = 1; mem_addr_i = 32'h0000_1004; r_size_i = 3'd2;
    applyStimulus();
    applyStimulus();
    checkVal("lw_req", {31'd0, data_req}, 32'd1);
    checkVal("lw_size", {30'd0, data_size}, 32'd2);
    data_addr_ok = 1;
    applyStimulus();
    data_addr_ok = 0;
    applyStimulus();
    checkVal("lw_wait_req", {31'd0, data_req}, 32'd0);
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    checkVal("lw_rdata", rdata_o, 32'hDEAD_BEEF);
    checkVal("lw_done_stall", {31'd0, stall_o}, 32'd0);
    mem_ce_i = 0; data_data_ok = 0;
    applyStimulus();

    // Store byte
    mem_we_i = 4'b0100; mem_wdata_i = 32'h00AA_0000; mem_addr_i = 32'h0000_2002; w_size_i = 3'd0;
    applyStimulus();
    checkVal("sb_wr", {31'd0, data_wr}, 32'd1);
    checkVal("sb_strb", {28'd0, data_wstrb}, 32'h4);
    checkVal("sb_size", {30'd0, data_size}, 32'd0);
    checkVal("sb_wdata", data_wdata, 32'h00AA_0000);
    data_addr_ok = 1;
    applyStimulus();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_5555;
    applyStimulus();
    checkVal("sb_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    mem_we_i = 0; data_data_ok = 0;
    applyStimulus();

    // addr_ok and data_ok together
    mem_ce_i = 1; mem_addr_i = 32'h0000_3000; r_size_i = 3'd2;
    applyStimulus();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1234_5678;
    applyStimulus();
    checkVal("fast_rdata", rdata_o, 32'h1234_5678);
    checkVal("fast_stall", {31'd0, stall_o}, 32'd0);
    mem_ce_i = 0; data_addr_ok = 0; data_data_ok = 0;
    applyStimulus();

    // Flush in WAIT, next load waits for the discarded response
    mem_ce_i = 1; mem_addr_i = 32'h0000_4000;
    applyStimulus();
    data_addr_ok = 1;
    applyStimulus();
    data_addr_ok = 0; flush_i = 1;
    applyStimulus();
    flush_i = 0; mem_addr_i = 32'h0000_4100;
    applyStimulus();
    applyStimulus();
    checkVal("cancel_req", {31'd0, data_req}, 32'd0);
    checkVal("cancel_stall", {31'd0, stall_o}, 32'd1);
    data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
    applyStimulus();
    checkVal("cancel_discard", rdata_o, 32'h1234_5678);
    checkVal("cancel_idle_req", {31'd0, data_req}, 32'd0);
    data_data_ok = 0;
    applyStimulus();
    checkVal("second_req", {31'd0, data_req}, 32'd1);
    checkVal("second_addr", data_addr, 32'h0000_4100);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    applyStimulus();
    checkVal("second_rdata", rdata_o, 32'hCAFE_F00D);
    mem_ce_i = 0; data_addr_ok = 0; data_data_ok = 0;
    applyStimulus();

    // Downstream stall held in DONE
    mem_ce_i = 1; mem_addr_i = 32'h0000_5000; r_size_i = 3'd1;
    applyStimulus();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h0000_BEEF;
    applyStimulus();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h7777_7777; pipe_stall_i = 1;
    repeat (5) applyStimulus();
    checkVal("hold_rdata", rdata_o, 32'h0000_BEEF);
    checkVal("hold_req", {31'd0, data_req}, 32'd0);
    pipe_stall_i = 0; mem_ce_i = 0;
    applyStimulus();
    applyStimulus();

    // Reset in WAIT, late data_ok ignored
    mem_ce_i = 1; mem_addr_i = 32'h0000_6000; r_size_i = 3'd2;
    applyStimulus();
    data_addr_ok = 1;
    applyStimulus();
    data_addr_ok = 0; rst = 0;
    applyStimulus();
    rst = 1;
    checkVal("rst_req", {31'd0, data_req}, 32'd0);
    checkVal("rst_addr", data_addr, 32'd0);
    checkVal("rst_rdata", rdata_o, 32'd0);
    checkVal("rst_stall", {31'd0, stall_o}, 32'd0);
    data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
    applyStimulus();
    checkVal("late_ok_rdata", rdata_o, 32'd0);
    checkVal("late_ok_req", {31'd0, data_req}, 32'd0);
    idleInputs();
    applyStimulus();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      rst  = ($urandom_range(0, 79) != 0);
      kind = $urandom_range(0, 3);
      mem_ce_i    = (kind == 1);
      mem_we_i    = (kind == 2) ? strbs[$urandom_range(0, 6)] : 4'd0;
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
      r_size_i    = 3'($urandom_range(0, 7));
      w_size_i    = 3'($urandom_range(0, 7));
      flush_i     = ($urandom_range(0, 9) == 0);
      pipe_stall_i = ($urandom_range(0, 2) == 0);
      data_addr_ok = ($urandom_range(0, 1) == 0);
      data_data_ok = ($urandom_range(0, 2) == 0);
      data_rdata   = $urandom;
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
